// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding and byte width for the SPI burst sequencer
package spi_pkg;
  localparam int SPI_BYTE_W = 8;
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_RX, DONE} state_t;
endpackage

// File: rtl/spi_byte_fifo.sv
// spi_byte_fifo: synchronous show-ahead byte FIFO with occupancy count
// Ports: clk, rst_n (sync, active low), wr/din push, rd/dout pop (dout is the head),
//        full, empty, count (occupancy, never exceeds DEPTH).
module spi_byte_fifo import spi_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [SPI_BYTE_W-1:0] din,
  input  logic                  rd,
  output logic [SPI_BYTE_W-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count
);
  localparam int PW = $clog2(DEPTH);
  logic [SPI_BYTE_W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic push, pop;
  assign push  = wr && !full;
  assign pop   = rd && !empty;
  assign full  = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  // Head is forced to zero when empty so the output is defined straight out of reset.
  assign dout  = empty ? '0 : mem[rp];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wp] <= din;
endmodule

// File: rtl/spi_burst_sequencer.sv
// spi_burst_sequencer: feeds a host-loaded byte burst to an SPI master one transaction at a time
// Ports: host TX FIFO (i_TX_Wr/i_TX_Data/o_TX_Full/o_TX_Count), host RX FIFO (i_RX_Rd/o_RX_Data/
//        o_RX_Empty), burst control (i_Start/i_Len/i_CPOL/i_CPHA -> o_Busy/o_Done/o_Err/o_RX_Ovf),
//        master side (o_CPOL/o_CPHA, o_Master_TX_Byte/o_Master_TX_DV/i_Master_TX_Ready,
//        i_Master_RX_DV/i_Master_RX_Byte). Sync active-low reset i_Rst_L.
module spi_burst_sequencer import spi_pkg::*; #(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 5
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_TX_Wr,
  input  logic [SPI_BYTE_W-1:0] i_TX_Data,
  output logic                  o_TX_Full,
  output logic [LEN_W-1:0]      o_TX_Count,
  input  logic                  i_RX_Rd,
  output logic [SPI_BYTE_W-1:0] o_RX_Data,
  output logic                  o_RX_Empty,
  input  logic                  i_Start,
  input  logic [LEN_W-1:0]      i_Len,
  input  logic                  i_CPOL,
  input  logic                  i_CPHA,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Err,
  output logic                  o_RX_Ovf,
  output logic                  o_CPOL,
  output logic                  o_CPHA,
  output logic [SPI_BYTE_W-1:0] o_Master_TX_Byte,
  output logic                  o_Master_TX_DV,
  input  logic                  i_Master_TX_Ready,
  input  logic                  i_Master_RX_DV,
  input  logic [SPI_BYTE_W-1:0] i_Master_RX_Byte
);
  state_t state, next;
  logic [LEN_W-1:0] rem, rx_level_unused;
  logic [SPI_BYTE_W-1:0] tx_head;
  logic tx_empty, rx_full, tx_pop, rx_push, accept, err;
  assign accept  = state == IDLE && i_Start && i_Len != '0 && i_Len <= o_TX_Count;
  assign tx_pop  = state == LOAD && !tx_empty;
  assign rx_push = state == WAIT_RX && i_Master_RX_DV;
  assign o_Busy  = state != IDLE;
  assign o_Done  = state == DONE;
  assign o_Err   = err;
  assign o_Master_TX_DV = state == SEND && i_Master_TX_Ready;
  spi_byte_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(LEN_W)) u_tx (
    .clk(i_Clk), .rst_n(i_Rst_L), .wr(i_TX_Wr), .din(i_TX_Data), .rd(tx_pop),
    .dout(tx_head), .full(o_TX_Full), .empty(tx_empty), .count(o_TX_Count)
  );
  spi_byte_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(LEN_W)) u_rx (
    .clk(i_Clk), .rst_n(i_Rst_L), .wr(rx_push), .din(i_Master_RX_Byte), .rd(i_RX_Rd),
    .dout(o_RX_Data), .full(rx_full), .empty(o_RX_Empty), .count(rx_level_unused)
  );
  always_ff @(posedge i_Clk) state <= !i_Rst_L ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = accept ? LOAD : IDLE;
      LOAD:    next = SEND;
      SEND:    next = i_Master_TX_Ready ? WAIT_RX : SEND;
      WAIT_RX: next = !i_Master_RX_DV ? WAIT_RX : rem == LEN_W'(1) ? DONE : LOAD;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      rem              <= '0;
      err              <= 1'b0;
      o_RX_Ovf         <= 1'b0;
      o_CPOL           <= 1'b0;
      o_CPHA           <= 1'b0;
      o_Master_TX_Byte <= '0;
    end else begin
      err <= state == IDLE && i_Start && !accept;
      if (accept) begin
        rem      <= i_Len;
        o_CPOL   <= i_CPOL;
        o_CPHA   <= i_CPHA;
        o_RX_Ovf <= 1'b0;
      end
      if (tx_pop) o_Master_TX_Byte <= tx_head;
      // A returned byte always consumes one burst slot, even when it is dropped.
      if (rx_push) begin
        rem <= rem - LEN_W'(1);
        if (rx_full) o_RX_Ovf <= 1'b1;
      end
    end
  end
endmodule
